// File: rtl/disease_pkg.sv
// Shared definitions for the agent loader: agent count, bus widths, state encodings.
package disease_pkg;

    localparam int NUM_AGENTS = 4;
    localparam int ADDR_W     = 2;
    localparam int SEED_W     = 32;

    localparam logic SUS = 1'b0;
    localparam logic INF = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_CFG = 3'd1,
        ST_SEED     = 3'd2,
        ST_STATE    = 3'd3,
        ST_RUN      = 3'd4,
        ST_DONE     = 3'd5
    } loader_state_e;

endpackage

// File: rtl/agent_popcount.sv
// Combinational count of infected agents in a 4-bit state vector.
module agent_popcount (
    input  logic [3:0] bits,
    output logic [2:0] count
);

    assign count = {2'b00, bits[0]} + {2'b00, bits[1]} + {2'b00, bits[2]} + {2'b00, bits[3]};

endmodule

// File: rtl/agent_loader.sv
// Loads seed/state into four agents, then runs and accumulates the infected count.
// Optional peak tracking is enabled by defining AGENT_LOADER_PEAK_EN.
//
// state     | meaning
// IDLE      | waiting for start; infected_sum holds last result
// WAIT_CFG  | cfg_ready high, waiting for the next agent's config beat
// SEED      | one-cycle loadSeed strobe to agent[index]
// STATE     | one-cycle loadState strobe to agent[index]
// RUN       | accumulating popcount(currState) for run_cycles cycles
// DONE      | one-cycle done pulse
module agent_loader
    import disease_pkg::*;
#(
    parameter int RUN_W = 16,
    parameter int SUM_W = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [RUN_W-1:0]      run_cycles,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [SEED_W-1:0]     cfg_seed,
    input  logic                  cfg_state,
    output logic [ADDR_W-1:0]     address,
    output logic [SEED_W-1:0]     seedValue,
    output logic                  loadSeed,
    output logic                  initState,
    output logic                  loadState,
    input  logic [NUM_AGENTS-1:0] currState,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            infected_now,
    output logic [SUM_W-1:0]      infected_sum,
    output logic [2:0]            peak_infected,
    output logic [RUN_W-1:0]      peak_cycle
);

    loader_state_e     state;
    logic [RUN_W-1:0]  run_len;
    logic [RUN_W-1:0]  run_cnt;
    logic [ADDR_W-1:0] index;
    logic [SEED_W-1:0] seed_q;
    logic              state_q;
    logic [2:0]        pop;
    logic [SUM_W:0]    sum_ext;

    agent_popcount u_popcount (
        .bits  (currState),
        .count (pop)
    );

    // One extra bit catches the carry so the sum can clamp at all-ones.
    assign sum_ext = {1'b0, infected_sum} + {{(SUM_W-2){1'b0}}, pop};

    assign cfg_ready = (state == ST_WAIT_CFG);
    assign loadSeed  = (state == ST_SEED);
    assign loadState = (state == ST_STATE);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign address   = index;
    assign seedValue = seed_q;
    assign initState = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            run_len      <= '0;
            run_cnt      <= '0;
            index        <= '0;
            seed_q       <= '0;
            state_q      <= 1'b0;
            infected_now <= '0;
            infected_sum <= '0;
        end else begin
            infected_now <= pop;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        run_len      <= run_cycles;
                        infected_sum <= '0;
                        index        <= '0;
                        state        <= ST_WAIT_CFG;
                    end
                end
                ST_WAIT_CFG: begin
                    if (cfg_valid) begin
                        seed_q  <= cfg_seed;
                        state_q <= cfg_state;
                        state   <= ST_SEED;
                    end
                end
                ST_SEED: state <= ST_STATE;
                ST_STATE: begin
                    if (index != ADDR_W'(NUM_AGENTS - 1)) begin
                        index <= index + ADDR_W'(1);
                        state <= ST_WAIT_CFG;
                    end else if (run_len == '0) begin
                        state <= ST_DONE;
                    end else begin
                        run_cnt <= run_len - RUN_W'(1);
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    infected_sum <= sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
                    if (run_cnt == '0) begin
                        state <= ST_DONE;
                    end else begin
                        run_cnt <= run_cnt - RUN_W'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef AGENT_LOADER_PEAK_EN
    logic [2:0]       peak_q;
    logic [RUN_W-1:0] peak_cyc_q;

    // Strict compare keeps the first cycle at which the maximum was seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q     <= '0;
            peak_cyc_q <= '0;
        end else if (state == ST_IDLE && start) begin
            peak_q     <= '0;
            peak_cyc_q <= '0;
        end else if (state == ST_RUN && pop > peak_q) begin
            peak_q     <= pop;
            peak_cyc_q <= run_len - RUN_W'(1) - run_cnt;
        end
    end

    assign peak_infected = peak_q;
    assign peak_cycle    = peak_cyc_q;
`else
    assign peak_infected = '0;
    assign peak_cycle    = '0;
`endif

endmodule
